// File: rtl/servile_wb_rr_arbiter.sv
// servile_wb_rr_arbiter: shares one Wishbone-classic slave between three
// masters (M0 ibus read-only, M1 dbus, M2 loader). One transaction at a time,
// round-robin or fixed priority, one idle turnaround cycle after each ack.
// Optional watchdog: define SERVILE_ARB_TIMEOUT_EN to terminate hung cycles.
module servile_wb_rr_arbiter #(
   parameter int unsigned FIXED_PRIO     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDT    = 32'hDEADBEEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [95:0] i_m_adr,
   input  logic [95:0] i_m_dat,
   input  logic [11:0] i_m_sel,
   input  logic [2:0]  i_m_we,
   input  logic [2:0]  i_m_stb,
   output logic [31:0] o_m_rdt,
   output logic [2:0]  o_m_ack,
   output logic [31:0] o_s_adr,
   output logic [31:0] o_s_dat,
   output logic [3:0]  o_s_sel,
   output logic        o_s_we,
   output logic        o_s_stb,
   input  logic [31:0] i_s_rdt,
   input  logic        i_s_ack,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] G_NONE = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  r_grant;
   logic [1:0]  r_last;
   logic [31:0] r_s_adr;
   logic [31:0] r_s_dat;
   logic [3:0]  r_s_sel;
   logic        r_s_we;
   logic        r_s_stb;
   logic [31:0] r_m_rdt;
   logic [2:0]  r_m_ack;
   logic        r_timeout;

   logic [1:0]  w_c0;
   logic [1:0]  w_c1;
   logic [1:0]  w_c2;
   logic [1:0]  w_win;
   logic        w_win_vld;
   logic [31:0] w_adr;
   logic [31:0] w_dat;
   logic [3:0]  w_sel;
   logic        w_we;
   logic        w_unused_cfg;

   function automatic logic [1:0] f_next(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   assign w_c0      = f_next(r_last);
   assign w_c1      = f_next(w_c0);
   assign w_c2      = r_last;
   assign w_win_vld = |i_m_stb;

   // M0's write enable is never forwarded; parameters consumed only under the macro
   assign w_unused_cfg = &{1'b0, i_m_we[0], TIMEOUT_RDT[0], TIMEOUT_CYCLES[0]};

   // Winner selection: fixed M0>M1>M2, or rotate starting after the last owner
   always_comb begin
      w_win = G_NONE;
      if (FIXED_PRIO != 0) begin
         if (i_m_stb[0])      w_win = 2'd0;
         else if (i_m_stb[1]) w_win = 2'd1;
         else if (i_m_stb[2]) w_win = 2'd2;
      end else begin
         if (i_m_stb[w_c0])      w_win = w_c0;
         else if (i_m_stb[w_c1]) w_win = w_c1;
         else if (i_m_stb[w_c2]) w_win = w_c2;
      end
   end

   // Route the winning master's request fields; M0 is forced to read
   always_comb begin
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      w_we  = 1'b0;
      case (w_win)
         2'd0: begin
            w_adr = i_m_adr[31:0];
            w_dat = i_m_dat[31:0];
            w_sel = i_m_sel[3:0];
            w_we  = 1'b0;
         end
         2'd1: begin
            w_adr = i_m_adr[63:32];
            w_dat = i_m_dat[63:32];
            w_sel = i_m_sel[7:4];
            w_we  = i_m_we[1];
         end
         2'd2: begin
            w_adr = i_m_adr[95:64];
            w_dat = i_m_dat[95:64];
            w_sel = i_m_sel[11:8];
            w_we  = i_m_we[2];
         end
         default: ;
      endcase
   end

`ifdef SERVILE_ARB_TIMEOUT_EN
   localparam logic [7:0] WDOG_LIM = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_wdog;
`endif

   // Arbitration FSM: grant, hold the slave cycle, return ack/data, turnaround
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_grant   <= G_NONE;
         r_last    <= 2'd2;
         r_s_adr   <= '0;
         r_s_dat   <= '0;
         r_s_sel   <= '0;
         r_s_we    <= 1'b0;
         r_s_stb   <= 1'b0;
         r_m_rdt   <= '0;
         r_m_ack   <= '0;
         r_timeout <= 1'b0;
`ifdef SERVILE_ARB_TIMEOUT_EN
         r_wdog    <= '0;
`endif
      end else begin
         r_m_ack   <= '0;
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_grant <= w_win;
                  r_s_adr <= w_adr;
                  r_s_dat <= w_dat;
                  r_s_sel <= w_sel;
                  r_s_we  <= w_we;
                  r_s_stb <= 1'b1;
                  r_state <= S_BUSY;
`ifdef SERVILE_ARB_TIMEOUT_EN
                  r_wdog  <= '0;
`endif
               end
            end
            S_BUSY: begin
               if (!i_m_stb[r_grant]) begin
                  r_s_stb <= 1'b0;
                  r_grant <= G_NONE;
                  r_state <= S_IDLE;
               end else if (i_s_ack) begin
                  r_m_rdt <= i_s_rdt;
                  r_m_ack <= 3'b001 << r_grant;
                  r_s_stb <= 1'b0;
                  r_last  <= r_grant;
                  r_grant <= G_NONE;
                  r_state <= S_DONE;
               end
`ifdef SERVILE_ARB_TIMEOUT_EN
               else if (r_wdog == WDOG_LIM) begin
                  r_m_rdt   <= TIMEOUT_RDT;
                  r_m_ack   <= 3'b001 << r_grant;
                  r_timeout <= 1'b1;
                  r_s_stb   <= 1'b0;
                  r_last    <= r_grant;
                  r_grant   <= G_NONE;
                  r_state   <= S_DONE;
               end else begin
                  r_wdog <= r_wdog + 8'd1;
               end
`endif
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_m_rdt   = r_m_rdt;
   assign o_m_ack   = r_m_ack;
   assign o_s_adr   = r_s_adr;
   assign o_s_dat   = r_s_dat;
   assign o_s_sel   = r_s_sel;
   assign o_s_we    = r_s_we;
   assign o_s_stb   = r_s_stb;
   assign o_grant   = r_grant;
   assign o_timeout = r_timeout;

endmodule
